// File: rtl/am2910.sv
// Am2910 microprogram sequencer: microprogram counter, loop/branch register-counter
// and a DEPTH-entry subroutine/loop stack, with an asynchronous active-low reset.
module am2910 #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 5
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic [3:0]       I,
  input  logic [WIDTH-1:0] D,
  input  logic             nCC,
  input  logic             nCCEN,
  input  logic             CI,
  input  logic             nRLD,
  input  logic             nOE,
  output logic [WIDTH-1:0] Y,
  output logic             nFULL,
  output logic             nPL,
  output logic             nMAP,
  output logic             nVECT
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);
  localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
  localparam logic [SPW-1:0] SP_LAST = SPW'(DEPTH - 1);

  typedef enum logic [3:0] {
    JZ   = 4'd0,
    CJS  = 4'd1,
    JMAP = 4'd2,
    CJP  = 4'd3,
    PUSH = 4'd4,
    JSRP = 4'd5,
    CJV  = 4'd6,
    JRP  = 4'd7,
    RFCT = 4'd8,
    RPCT = 4'd9,
    CRTN = 4'd10,
    CJPP = 4'd11,
    LDCT = 4'd12,
    LOOP = 4'd13,
    CONT = 4'd14,
    TWB  = 4'd15
  } instr_e;

  logic [WIDTH-1:0] upc;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] stack [DEPTH];
  logic [SPW-1:0]   sp;

  logic [WIDTH-1:0] tos;
  logic [WIDTH-1:0] y_int;
  logic [SPW-1:0]   push_idx;
  logic             pass, rz, full;
  logic             push, pop, clear, load_r, dec_r;
  instr_e           instr;

  assign instr    = instr_e'(I);
  assign pass     = nCCEN | ~nCC;
  assign rz       = (r == '0);
  assign full     = (sp == SP_FULL);
  assign tos      = (sp == '0) ? '0 : stack[sp - SP_ONE];
  assign push_idx = full ? SP_LAST : sp;
  assign nFULL    = ~full;
  assign Y        = nOE ? {WIDTH{1'bz}} : y_int;

  // Address select and side-effect decode; Y is forced to 0 while reset is held.
  always_comb begin
    y_int  = upc;
    push   = 1'b0;
    pop    = 1'b0;
    clear  = 1'b0;
    load_r = 1'b0;
    dec_r  = 1'b0;
    case (instr)
      JZ:   begin y_int = '0; clear = 1'b1; end
      CJS:  if (pass) begin y_int = D; push = 1'b1; end
      JMAP: y_int = D;
      CJP:  if (pass) y_int = D;
      PUSH: begin push = 1'b1; load_r = pass; end
      JSRP: begin push = 1'b1; y_int = pass ? D : r; end
      CJV:  if (pass) y_int = D;
      JRP:  y_int = pass ? D : r;
      RFCT: if (!rz) begin y_int = tos; dec_r = 1'b1; end
            else pop = 1'b1;
      RPCT: if (!rz) begin y_int = D; dec_r = 1'b1; end
      CRTN: if (pass) begin y_int = tos; pop = 1'b1; end
      CJPP: if (pass) begin y_int = D; pop = 1'b1; end
      LDCT: load_r = 1'b1;
      LOOP: if (pass) pop = 1'b1;
            else y_int = tos;
      CONT: y_int = upc;
      TWB: begin
        if (pass) begin
          pop   = 1'b1;
          dec_r = !rz;
        end else if (!rz) begin
          y_int = tos;
          dec_r = 1'b1;
        end else begin
          y_int = D;
          pop   = 1'b1;
        end
      end
      default: y_int = upc;
    endcase
    if (!nRST) y_int = '0;
  end

  always_comb begin
    nPL   = 1'b1;
    nMAP  = 1'b1;
    nVECT = 1'b1;
    if (nRST) begin
      case (instr)
        JMAP:    nMAP  = 1'b0;
        CJV:     nVECT = 1'b0;
        default: nPL   = 1'b0;
      endcase
    end
  end

  // A full stack overwrites its top entry; popping an empty stack is a no-op.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      upc <= '0;
      r   <= '0;
      sp  <= '0;
      for (int k = 0; k < DEPTH; k++) stack[k] <= '0;
    end else begin
      upc <= y_int + WIDTH'(CI);
      if (!nRLD || load_r) r <= D;
      else if (dec_r)      r <= r - WIDTH'(1);
      if (clear) sp <= '0;
      else if (push) begin
        stack[push_idx] <= upc;
        if (!full) sp <= sp + SP_ONE;
      end else if (pop && sp != '0) begin
        sp <= sp - SP_ONE;
      end
    end
  end

endmodule

// File: tb/tb_am2910.sv
// Directed-vector bench for am2910: a table of hand-computed steps followed by
// hand-written stack overflow, output-enable and asynchronous reset sequences.
module tb_am2910;

  localparam logic [3:0] JZ = 4'd0, CJS = 4'd1, JMAP = 4'd2, CJP = 4'd3;
  localparam logic [3:0] PUSH = 4'd4, JSRP = 4'd5, CJV = 4'd6, JRP = 4'd7;
  localparam logic [3:0] RFCT = 4'd8, RPCT = 4'd9, CRTN = 4'd10, CJPP = 4'd11;
  localparam logic [3:0] LDCT = 4'd12, LOOP = 4'd13, CONT = 4'd14, TWB = 4'd15;

  typedef struct {
    logic [3:0]  i;
    logic [11:0] d;
    logic        ncc;
    logic        nccen;
    logic        ci;
    logic        nrld;
    logic [11:0] y;
    logic        nfull;
  } vec_t;

  logic        clk = 1'b0;
  logic        nRST;
  logic [3:0]  I;
  logic [11:0] D;
  logic        nCC, nCCEN, CI, nRLD, nOE;
  wire  [11:0] Y;
  wire         nFULL, nPL, nMAP, nVECT;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  am2910 #(.WIDTH(12), .DEPTH(5)) dut (
    .clk(clk), .nRST(nRST), .I(I), .D(D), .nCC(nCC), .nCCEN(nCCEN),
    .CI(CI), .nRLD(nRLD), .nOE(nOE), .Y(Y), .nFULL(nFULL), .nPL(nPL),
    .nMAP(nMAP), .nVECT(nVECT)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  function automatic vec_t mk(input logic [3:0] i, input logic [11:0] d, input logic ncc,
                              input logic [11:0] y, input logic nfull = 1'b1,
                              input logic nccen = 1'b0, input logic ci = 1'b1,
                              input logic nrld = 1'b1);
    vec_t v;
    v.i = i; v.d = d; v.ncc = ncc; v.nccen = nccen; v.ci = ci; v.nrld = nrld;
    v.y = y; v.nfull = nfull;
    return v;
  endfunction

  // {nPL, nMAP, nVECT} for a decoded instruction outside reset
  function automatic logic [2:0] exp_en(input logic [3:0] i);
    if (i == JMAP) return 3'b101;
    if (i == CJV)  return 3'b110;
    return 3'b011;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    I = v.i; D = v.d; nCC = v.ncc; nCCEN = v.nccen; CI = v.ci; nRLD = v.nrld;
  endtask

  // Called just after a falling edge: drive, check mid-phase, wait for the next falling edge.
  task automatic runVector(input vec_t v, input string tag);
    applyStimulus(v);
    #2;
    checkOutput({tag, " y"}, 32'(Y), 32'(v.y));
    checkOutput({tag, " en"}, 32'({nPL, nMAP, nVECT}), 32'(exp_en(v.i)));
    checkOutput({tag, " nfull"}, 32'(nFULL), 32'(v.nfull));
    @(negedge clk);
  endtask

  initial begin
    vecs.push_back(mk(CONT, 12'h000, 1'b0, 12'h000));          // 0: reset start
    vecs.push_back(mk(CONT, 12'h000, 1'b0, 12'h001));
    vecs.push_back(mk(CONT, 12'h000, 1'b0, 12'h002));
    vecs.push_back(mk(JZ,   12'h7FF, 1'b0, 12'h000));
    vecs.push_back(mk(CJP,  12'h00F, 1'b0, 12'h00F));
    vecs.push_back(mk(CJS,  12'h100, 1'b0, 12'h100));          // 5: push 0x010
    vecs.push_back(mk(CONT, 12'h000, 1'b0, 12'h101));
    vecs.push_back(mk(CRTN, 12'h000, 1'b0, 12'h010));
    vecs.push_back(mk(CJS,  12'h300, 1'b1, 12'h011));
    vecs.push_back(mk(CRTN, 12'h000, 1'b1, 12'h012));
    vecs.push_back(mk(CJP,  12'h040, 1'b1, 12'h040, 1'b1, 1'b1)); // 10: nCCEN forces pass
    vecs.push_back(mk(CJP,  12'h050, 1'b1, 12'h041));
    vecs.push_back(mk(JMAP, 12'h0AB, 1'b1, 12'h0AB));
    vecs.push_back(mk(CJV,  12'h0C0, 1'b0, 12'h0C0));
    vecs.push_back(mk(CJV,  12'h0D0, 1'b1, 12'h0C1));
    vecs.push_back(mk(CONT, 12'h000, 1'b0, 12'h0C2, 1'b1, 1'b0, 1'b0)); // 15: CI=0 wait
    vecs.push_back(mk(CONT, 12'h000, 1'b0, 12'h0C2));
    vecs.push_back(mk(LDCT, 12'h003, 1'b0, 12'h0C3));
    vecs.push_back(mk(CJP,  12'h01F, 1'b0, 12'h01F));
    vecs.push_back(mk(PUSH, 12'h7FF, 1'b1, 12'h020));
    vecs.push_back(mk(RFCT, 12'h000, 1'b0, 12'h020));          // 20: R 3->2
    vecs.push_back(mk(RFCT, 12'h000, 1'b0, 12'h020));
    vecs.push_back(mk(RFCT, 12'h000, 1'b0, 12'h020));
    vecs.push_back(mk(RFCT, 12'h000, 1'b0, 12'h021));          // R=0: fall through, pop
    vecs.push_back(mk(CRTN, 12'h000, 1'b0, 12'h000));          // empty stack TOS
    vecs.push_back(mk(LDCT, 12'h005, 1'b0, 12'h001));          // 25
    vecs.push_back(mk(RPCT, 12'h009, 1'b0, 12'h009, 1'b1, 1'b0, 1'b1, 1'b0)); // nRLD wins
    vecs.push_back(mk(JRP,  12'h3FF, 1'b1, 12'h009));
    vecs.push_back(mk(JRP,  12'h123, 1'b0, 12'h123));
    vecs.push_back(mk(RPCT, 12'h200, 1'b0, 12'h200));
    vecs.push_back(mk(JRP,  12'h3FF, 1'b1, 12'h008));          // 30
    vecs.push_back(mk(LDCT, 12'h000, 1'b0, 12'h009));
    vecs.push_back(mk(RPCT, 12'h333, 1'b0, 12'h00A));
    vecs.push_back(mk(JSRP, 12'h444, 1'b1, 12'h000));
    vecs.push_back(mk(CRTN, 12'h000, 1'b0, 12'h00B));
    vecs.push_back(mk(JSRP, 12'h060, 1'b0, 12'h060));          // 35
    vecs.push_back(mk(LOOP, 12'h000, 1'b1, 12'h00C));
    vecs.push_back(mk(LOOP, 12'h000, 1'b0, 12'h00D));
    vecs.push_back(mk(PUSH, 12'h7FF, 1'b1, 12'h00E));
    vecs.push_back(mk(CJPP, 12'h070, 1'b0, 12'h070));
    vecs.push_back(mk(CRTN, 12'h000, 1'b0, 12'h000));          // 40
    vecs.push_back(mk(PUSH, 12'h004, 1'b0, 12'h001));
    vecs.push_back(mk(JRP,  12'h3FF, 1'b1, 12'h004));
    vecs.push_back(mk(TWB,  12'h3FF, 1'b1, 12'h001));
    vecs.push_back(mk(TWB,  12'h3FF, 1'b0, 12'h002));
    vecs.push_back(mk(JRP,  12'h3FF, 1'b1, 12'h002));          // 45
    vecs.push_back(mk(LDCT, 12'h000, 1'b0, 12'h003));
    vecs.push_back(mk(PUSH, 12'h7FF, 1'b1, 12'h004));
    vecs.push_back(mk(TWB,  12'h0EE, 1'b1, 12'h0EE));
    vecs.push_back(mk(CRTN, 12'h000, 1'b0, 12'h000));
    vecs.push_back(mk(JRP,  12'h3FF, 1'b1, 12'h000));          // 50

    nRST = 1'b0; nOE = 1'b0;
    applyStimulus(mk(JMAP, 12'hABC, 1'b0, 12'h000));
    #2;
    checkOutput("reset y", 32'(Y), 32'h0);
    checkOutput("reset en", 32'({nPL, nMAP, nVECT}), 32'h7);
    checkOutput("reset nfull", 32'(nFULL), 32'h1);
    @(negedge clk);
    nRST = 1'b1;

    foreach (vecs[k]) runVector(vecs[k], $sformatf("vec%0d", k));

    for (int k = 1; k <= 6; k++)
      runVector(mk(PUSH, 12'h7FF, 1'b1, 12'(k), (k == 6) ? 1'b0 : 1'b1), $sformatf("push%0d", k));
    runVector(mk(CONT, 12'h000, 1'b0, 12'h007, 1'b0), "full cont");
    begin
      logic [11:0] ret [6];
      ret = '{12'h006, 12'h004, 12'h003, 12'h002, 12'h001, 12'h000};
      for (int k = 0; k < 6; k++)
        runVector(mk(CRTN, 12'h000, 1'b0, ret[k], (k == 0) ? 1'b0 : 1'b1), $sformatf("crtn%0d", k));
    end

    runVector(mk(JMAP, 12'h5A5, 1'b0, 12'h5A5), "map oe");
    nOE = 1'b1;
    applyStimulus(mk(JMAP, 12'h5A5, 1'b0, 12'h000));
    #2;
    checks++;
    if (Y === 12'h5A5) begin
      errors++;
      $display("[TB] FAIL oe_hiz: got %h expected not driven", Y);
    end
    checkOutput("oe_hiz en", 32'({nPL, nMAP, nVECT}), 32'h5);
    @(negedge clk);
    nOE = 1'b0;
    runVector(mk(CONT, 12'h000, 1'b0, 12'h5A6), "after oe");

    runVector(mk(LDCT, 12'h002, 1'b0, 12'h5A7), "pre-rst ldct");
    runVector(mk(PUSH, 12'h7FF, 1'b1, 12'h5A8), "pre-rst push0");
    runVector(mk(PUSH, 12'h7FF, 1'b1, 12'h5A9), "pre-rst push1");
    runVector(mk(PUSH, 12'h7FF, 1'b1, 12'h5AA), "pre-rst push2");
    applyStimulus(mk(TWB, 12'h3FF, 1'b1, 12'h000));
    #2;
    checkOutput("twb y", 32'(Y), 32'h5AA);
    #1 nRST = 1'b0;
    #1;
    checkOutput("async y", 32'(Y), 32'h0);
    checkOutput("async en", 32'({nPL, nMAP, nVECT}), 32'h7);
    checkOutput("async nfull", 32'(nFULL), 32'h1);
    @(negedge clk);
    checkOutput("held y", 32'(Y), 32'h0);
    nRST = 1'b1;
    runVector(mk(CONT, 12'h000, 1'b0, 12'h000), "post-rst upc");
    runVector(mk(JRP,  12'h3FF, 1'b1, 12'h000), "post-rst r");
    runVector(mk(CRTN, 12'h000, 1'b0, 12'h000), "post-rst sp");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/am2910.md
# am2910

Microprogram sequencer that sits downstream of the status and shift control unit. It consumes the conditional-test output (CT, wired to `nCC` through an inverter) and produces the next microprogram address every clock. It holds a microprogram counter, a loop/branch register-counter and a subroutine/loop stack. It implements the Am2910 16-instruction set, extended with an asynchronous reset for deterministic start-up.

## Interface
- `WIDTH`, 12: address, register and stack-entry width.
- `DEPTH`, 5: stack entries.

Ports:
- `clk`  in  1: clock, all state updates on rising edge.
- `nRST`  in  1: reset, asynchronous, active-low.
- `I`  in  4: instruction.
- `D`  in  WIDTH: direct branch address / counter load value.
- `nCC`  in  1: condition code, low = condition true.
- `nCCEN`  in  1: condition enable; high forces pass.
- `CI`  in  1: carry-in to the microprogram-counter incrementer.
- `nRLD`  in  1: unconditional register load, active-low.
- `nOE`  in  1: Y output enable, active-low.
- `Y`  out  WIDTH: next microaddress; tri-state when `nOE` is high.
- `nFULL`  out  1: low when the stack holds DEPTH entries.
- `nPL`  out  1: pipeline-register enable, active-low.
- `nMAP`  out  1: map PROM enable, active-low.
- `nVECT`  out  1: vector enable, active-low.

## Operation
- **State:**
  - `uPC` (WIDTH)
  - `R` (WIDTH)
  - `SP` (0..DEPTH)
  - `stack[DEPTH]`
  - `TOS` = `stack[SP-1]`; `TOS` = 0 when `SP` = 0.
- **Condition:** `pass` = `nCCEN` | ~`nCC`. `Rz` = (`R` == 0), evaluated on the pre-edge value.
- **Next uPC:** `uPC` <= `Y` + `CI`, modulo 2^WIDTH. This happens every cycle, computed from the internal Y, independent of `nOE`.
- **Enables:**
  - `nMAP` is low only for I=2.
  - `nVECT` is low only for I=6.
  - `nPL` is low for all other instructions.
  - Exactly one enable is low at any time.
- **Instructions** (Y select; side effects):
  - 0 JZ: Y=0; SP<=0.
  - 1 CJS: pass: Y=D, push uPC. Fail: Y=uPC.
  - 2 JMAP: Y=D.
  - 3 CJP: pass: Y=D. Fail: Y=uPC.
  - 4 PUSH: Y=uPC; push uPC; if pass, R<=D.
  - 5 JSRP: push uPC; pass: Y=D. Fail: Y=R.
  - 6 CJV: pass: Y=D. Fail: Y=uPC.
  - 7 JRP: pass: Y=D. Fail: Y=R.
  - 8 RFCT: if ~Rz, Y=TOS and R<=R-1. If Rz, Y=uPC and pop.
  - 9 RPCT: if ~Rz, Y=D and R<=R-1. If Rz, Y=uPC.
  - 10 CRTN: pass: Y=TOS, pop. Fail: Y=uPC.
  - 11 CJPP: pass: Y=D, pop. Fail: Y=uPC.
  - 12 LDCT: Y=uPC; R<=D.
  - 13 LOOP: pass: Y=uPC, pop. Fail: Y=TOS.
  - 14 CONT: Y=uPC.
  - 15 TWB: pass: Y=uPC, pop, and R<=R-1 if ~Rz. Fail with ~Rz: Y=TOS, R<=R-1. Fail with Rz: Y=D, pop.
- **Push:** `stack[SP]`<=uPC, SP<=SP+1.
  - When full (SP=DEPTH), `stack[DEPTH-1]` is overwritten and SP stays at DEPTH.
- **Pop:** SP<=SP-1; when SP=0, no change.
- **`nRLD` low:** R<=D regardless of instruction. This overrides any decrement in the same cycle.
- **`nFULL`:** combinational from SP.

## Timing
- Y and the enables are combinational from `I`, `nCC`, `nCCEN`, `D` and the current state, with zero-cycle latency. State updates on the next rising edge.
- **Reset** (async assert, state held while low):
  - uPC=0, R=0, SP=0, all stack entries 0.
  - While `nRST` is low: Y is driven 0 (if `nOE` is low), `nPL`=`nMAP`=`nVECT`=1, `nFULL`=1.
  - After release, the first edge executes normally.
- **Mid-operation reset:** a pending push, pop or decrement is discarded. There are no partial updates.
- **R decrement:** wraps only when no Rz test guards it. That is impossible by construction, so R never underflows.
- **`CI`=0:** uPC <= Y, so the current address is re-issued (wait state).

## Test plan
- **Reset, then CONT with CI=1 for 3 cycles:** Y = 0,1,2. uPC=3 after the third edge. `nPL`=0, `nFULL`=1.
- **CJS with pass, D=0x100, at uPC=0x010:** Y=0x100, stack[0]=0x010, SP=1. Follow with CONT, then CRTN with pass: Y=0x101 on the CONT cycle, then Y=0x010 on CRTN, SP=0.
- **Stack overflow:**
  - Six PUSHes at uPC=1..6: `nFULL` goes low after the 5th push; after the 6th push stack[4]=6 and SP=5.
  - Six CRTNs: return 6,4,3,2,1, then 0 (empty TOS), with SP remaining 0.
- **Loop counter:** LDCT with D=3, then RFCT with TOS=0x020. Y=0x020 three times (R: 3→2→1→0), then Y=uPC with a pop on the 4th RFCT.
- **Override:** RPCT with R=5 and `nRLD`=0, D=9 gives R=9 (not 4) and Y=D. Also check I=2 gives `nMAP`=0, I=6 gives `nVECT`=0, and `nOE`=1 gives Y=z.
- **Async reset:** assert `nRST` mid-TWB with R=2, SP=3. All state reads 0 immediately, before the next edge.
